spi_target_if: RTL and testbench
================================

Name: spi_target_if

Overview:
- SPI target (slave) endpoint: the responder for the SPI controller whose SCLK comes from the on-chip clock dividers.
- Oversamples external i_sclk, i_cs_n and i_mosi in the i_clk domain.
- Deserialises MOSI words to a parallel valid pulse and serialises a parallel transmit word onto MISO.
- Sits between the SPI pins and the register/user logic.

Parameters:
- DATA_W, 8, bits per SPI word (4..32).
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0: sample on leading edge; 1: sample on trailing edge.
- MSB_FIRST, 1, 1: MSB first on both lines; 0: LSB first.

Ports:
- i_clk  input  1  system clock; i_sclk frequency must be ≤ i_clk/4.
- i_rst  input  1  reset, synchronous, active-high.
- i_sclk  input  1  SPI clock from controller, asynchronous.
- i_cs_n  input  1  chip select, active-low, asynchronous.
- i_mosi  input  1  controller-out data, asynchronous.
- o_miso  output  1  target-out data.
- o_miso_oe  output  1  MISO pad output enable.
- i_tx_data  input  DATA_W  next word to transmit.
- i_tx_valid  input  1  i_tx_data valid.
- o_tx_ready  output  1  holding buffer empty; capture when i_tx_valid && o_tx_ready.
- o_rx_data  output  DATA_W  last complete received word.
- o_rx_valid  output  1  one-cycle pulse when o_rx_data updates.
- o_tx_underrun  output  1  one-cycle pulse: word started with empty tx buffer.
- o_busy  output  1  transfer in progress (ACTIVE state).

Behaviour:
- Reset (synchronous, i_rst=1 at i_clk rise):
  - Outputs: o_miso=0, o_miso_oe=0, o_tx_ready=1, o_rx_data=0, o_rx_valid=0, o_tx_underrun=0, o_busy=0.
  - Internal: tx buffer empty, counters cleared, synchronizers reset to idle levels (sclk=CPOL, cs_n=1).
- Synchronisation:
  - Each async input passes through 2 flops, plus 1 history flop for edge detect on sclk and cs_n.
  - An i_sclk transition first sampled at i_clk edge N is acted on at edge N+2.
  - o_rx_valid is high in the cycle after edge N+2.
- Edges:
  - Leading edge = rising if CPOL=0, else falling.
  - Sample edge = leading if CPHA=0, else trailing; shift edge = the other.
- FSM states:
  - WAIT_IDLE: entered after reset. Goes to IDLE once sync cs_n=1, so a reset mid-transfer ignores the rest of that frame.
  - IDLE: on sync cs_n falling edge → ACTIVE and load the word (see word load).
  - ACTIVE:
    - On each sample edge, shift the sync mosi into rx_shift and increment bit_cnt.
    - On each shift edge, advance tx_shift and update o_miso. When CPHA=0, the first shift edge of a word is suppressed because the bit was already driven at load.
    - When bit_cnt reaches DATA_W-1 and a sample occurs: o_rx_data <= assembled word, pulse o_rx_valid, bit_cnt <= 0, and load the next word.
    - Next-word load timing: CPHA=0 loads immediately; CPHA=1 loads on the next leading edge.
    - On sync cs_n rising edge → IDLE from any point. A partial word is discarded (no o_rx_valid), bit_cnt=0, and the tx word in flight is lost.
- Word load:
  - Buffer full: tx_shift <= buffer, buffer empties, o_tx_ready rises next cycle.
  - Buffer empty: tx_shift <= 0 and o_tx_underrun pulses.
  - CPHA=0: first bit on o_miso in the load cycle.
  - CPHA=1: first bit on o_miso at the first leading edge.
- Tx handshake:
  - o_tx_ready is registered as !buffer_full.
  - If a capture coincides with a load, the load takes the old buffer content and the new data fills the buffer.
  - The buffer can be written in IDLE or ACTIVE.
- o_miso_oe = 1 exactly while the FSM is in ACTIVE; o_miso = 0 outside ACTIVE.
- Bit order: MSB_FIRST selects shift direction and MOSI insertion end; it applies identically to tx and rx.
- o_rx_data holds its value until the next complete word.

Decomposition:
- Package spi_pkg:
  - FSM state enum (WAIT_IDLE, IDLE, ACTIVE).
  - Mode constants SPI_MODE0..3 as {CPOL,CPHA}.
  - Function computing the sample/shift edge selects from CPOL/CPHA.
- Sub-module spi_in_sync: 2-flop synchronizer plus rise/fall pulse outputs, instantiated for sclk, cs_n and mosi (edges unused for mosi).

Test Plan:
- Mode 0, DATA_W=8, sclk=i_clk/8: tx buffer preloaded 0x3C, controller sends 0xA5 → o_rx_data=0xA5 with one o_rx_valid pulse; controller captures 0x3C on MISO; o_tx_ready low→high after load.
- Mode 3, same data → identical rx/tx values; first MISO bit appears only after the first falling sclk edge.
- CS held low for two back-to-back words 0x01, 0x80 with tx 0xF0 then 0x0F queued during word 1 → two rx_valid pulses carrying 0x01 and 0x80; MISO carries 0xF0 then 0x0F; no underrun.
- Empty tx buffer at CS fall → o_tx_underrun one pulse; MISO all zeros; rx still 0xA5.
- CS rises after 5 bits → no o_rx_valid, o_busy=0. Next full frame 0x5A → o_rx_data=0x5A (no stale bits).
- i_rst pulsed after bit 3 with CS still low → remaining bits ignored, no o_rx_valid. After CS high then low, 0xC3 is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : spi_pkg
// Brief    : Shared types and helpers for the SPI target endpoint.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_ACTIVE    = 2'd2
    } spi_state_t;

    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef struct packed {
        logic sample_rise;
        logic shift_rise;
    } spi_edge_sel_t;

    // Sampling happens on the rising sclk edge exactly when CPOL equals CPHA.
    function automatic spi_edge_sel_t spi_edge_sel(input logic cpol, input logic cpha);
        spi_edge_sel_t sel;
        sel.sample_rise = (cpol == cpha);
        sel.shift_rise  = (cpol != cpha);
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_in_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : spi_in_sync
// Brief    : Two-flop synchronizer with history flop for edge pulses.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module spi_in_sync #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_hist <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_hist;
    assign o_fall  = ~r_sync & r_hist;

endmodule
`default_nettype wire

// File: rtl/spi_target_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : spi_target_if
// Brief    : Oversampled SPI target: MOSI deserialiser, MISO serialiser, 1-deep tx buffer.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module spi_target_if
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sclk,
    input  logic              i_cs_n,
    input  logic              i_mosi,
    output logic              o_miso,
    output logic              o_miso_oe,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_tx_underrun,
    output logic              o_busy
);

    localparam int                 c_CNT_W = $clog2(DATA_W);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_W - 1);
    localparam spi_edge_sel_t      c_EDGE  = spi_edge_sel(CPOL, CPHA);

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    logic w_sclk_level_unused, w_sclk_rise, w_sclk_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_in_sync #(.RST_VAL(CPOL)) u_sync_sclk (
        .i_clk(i_clk), .i_rst(i_rst), .i_async(i_sclk),
        .o_level(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_in_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .i_clk(i_clk), .i_rst(i_rst), .i_async(i_cs_n),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    spi_in_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_clk), .i_rst(i_rst), .i_async(i_mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
    );

    spi_state_t          r_state, w_state_nxt;
    logic [1:0]          r_settle;
    logic [c_CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0]   r_rx_shift, r_tx_shift, r_buf, r_rx_data;
    logic                r_buf_full, r_tx_ready, r_rx_valid, r_underrun, r_miso, r_load_pending;

    logic                w_active, w_sample, w_shift, w_word_done, w_frame_start, w_load;
    logic                w_capture, w_buf_full_nxt;
    logic [DATA_W-1:0]   w_load_word, w_rx_next;

    assign w_active      = (r_state == ST_ACTIVE);
    assign w_sample      = w_active && !w_cs_rise && (c_EDGE.sample_rise ? w_sclk_rise : w_sclk_fall);
    assign w_shift       = w_active && !w_cs_rise && (c_EDGE.shift_rise  ? w_sclk_rise : w_sclk_fall);
    assign w_word_done   = w_sample && (r_bit_cnt == c_LAST);
    assign w_frame_start = (r_state == ST_IDLE) && w_cs_fall;
    assign w_load        = w_frame_start || ((CPHA == 1'b1) ? (w_shift && r_load_pending) : w_word_done);
    assign w_load_word   = r_buf_full ? r_buf : '0;
    assign w_rx_next     = MSB_FIRST ? {r_rx_shift[DATA_W-2:0], w_mosi} : {w_mosi, r_rx_shift[DATA_W-1:1]};
    assign w_capture     = i_tx_valid && r_tx_ready;
    assign w_buf_full_nxt = w_capture || (r_buf_full && !w_load);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_WAIT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The settle wait lets the cs_n chain hold real pin samples before leaving WAIT_IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT_IDLE: if (r_settle == 2'd2 && w_cs_level) w_state_nxt = ST_IDLE;
            ST_IDLE:      if (w_cs_fall)                      w_state_nxt = ST_ACTIVE;
            ST_ACTIVE:    if (w_cs_rise)                      w_state_nxt = ST_IDLE;
            default:                                          w_state_nxt = ST_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_settle       <= 2'd0;
            r_bit_cnt      <= '0;
            r_rx_shift     <= '0;
            r_tx_shift     <= '0;
            r_buf          <= '0;
            r_rx_data      <= '0;
            r_buf_full     <= 1'b0;
            r_tx_ready     <= 1'b1;
            r_rx_valid     <= 1'b0;
            r_underrun     <= 1'b0;
            r_miso         <= 1'b0;
            r_load_pending <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_underrun <= w_load && !r_buf_full;
            r_buf_full <= w_buf_full_nxt;
            r_tx_ready <= !w_buf_full_nxt;
            if (w_capture) r_buf <= i_tx_data;
            if (r_state == ST_WAIT_IDLE && r_settle != 2'd2) r_settle <= r_settle + 2'd1;

            if (w_active && w_cs_rise) begin
                r_bit_cnt      <= '0;
                r_load_pending <= 1'b0;
            end else begin
                if (w_frame_start) begin
                    r_bit_cnt      <= '0;
                    r_load_pending <= 1'b0;
                    r_rx_shift     <= '0;
                    if (CPHA == 1'b0) begin
                        r_miso     <= first_bit(w_load_word);
                        r_tx_shift <= shift_out(w_load_word);
                    end else begin
                        r_miso     <= 1'b0;
                        r_tx_shift <= w_load_word;
                    end
                end
                if (w_sample) begin
                    r_rx_shift <= w_rx_next;
                    if (r_bit_cnt == c_LAST) begin
                        r_bit_cnt  <= '0;
                        r_rx_data  <= w_rx_next;
                        r_rx_valid <= 1'b1;
                        if (CPHA == 1'b0) begin
                            r_miso     <= first_bit(w_load_word);
                            r_tx_shift <= shift_out(w_load_word);
                        end else begin
                            r_load_pending <= 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                // With CPHA=0 a word's first bit is driven at load, so its first shift edge is skipped.
                if (w_shift) begin
                    if (r_load_pending) begin
                        r_load_pending <= 1'b0;
                        r_miso         <= first_bit(w_load_word);
                        r_tx_shift     <= shift_out(w_load_word);
                    end else if (CPHA == 1'b1 || r_bit_cnt != '0) begin
                        r_miso     <= first_bit(r_tx_shift);
                        r_tx_shift <= shift_out(r_tx_shift);
                    end
                end
            end
        end
    end

    assign o_miso        = w_active && r_miso;
    assign o_miso_oe     = w_active;
    assign o_busy        = w_active;
    assign o_tx_ready    = r_tx_ready;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_tx_underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_target_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_spi_target_if
// Brief    : Bench for spi_target_if in mode 0 (index 0) and mode 3 (index 1).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_spi_target_if;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sclk = 2'b10;
    logic [1:0] cs_n = 2'b11;
    logic       mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [1:0] tx_valid = 2'b00;
    logic [1:0] miso, oe, tx_ready, rx_valid, urun, busy;
    logic [7:0] rx_data [2];

    int total = 0;
    int bad   = 0;
    int rxv_cnt [2];
    int urun_cnt [2];
    logic [7:0] rx_log [2][8];
    logic [7:0] txq0 [$];
    logic [7:0] txq1 [$];

    always #5 clk = ~clk;

    spi_target_if #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_dut_m0 (
        .i_clk(clk), .i_rst(rst), .i_sclk(sclk[0]), .i_cs_n(cs_n[0]), .i_mosi(mosi),
        .o_miso(miso[0]), .o_miso_oe(oe[0]), .i_tx_data(tx_data), .i_tx_valid(tx_valid[0]),
        .o_tx_ready(tx_ready[0]), .o_rx_data(rx_data[0]), .o_rx_valid(rx_valid[0]),
        .o_tx_underrun(urun[0]), .o_busy(busy[0])
    );
    spi_target_if #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) u_dut_m3 (
        .i_clk(clk), .i_rst(rst), .i_sclk(sclk[1]), .i_cs_n(cs_n[1]), .i_mosi(mosi),
        .o_miso(miso[1]), .o_miso_oe(oe[1]), .i_tx_data(tx_data), .i_tx_valid(tx_valid[1]),
        .o_tx_ready(tx_ready[1]), .o_rx_data(rx_data[1]), .o_rx_valid(rx_valid[1]),
        .o_tx_underrun(urun[1]), .o_busy(busy[1])
    );

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (rx_valid[m]) begin
                rx_log[m][rxv_cnt[m] % 8] = rx_data[m];
                rxv_cnt[m] = rxv_cnt[m] + 1;
            end
            if (urun[m]) urun_cnt[m] = urun_cnt[m] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference tx buffer: a load takes the oldest written word, or zero with an underrun.
    function automatic logic [8:0] model_load(input int m);
        logic [8:0] r;
        r = 9'h100;
        if (m == 0 && txq0.size() > 0) r = {1'b0, txq0.pop_front()};
        if (m == 1 && txq1.size() > 0) r = {1'b0, txq1.pop_front()};
        return r;
    endfunction

    function automatic int model_size(input int m);
        return (m == 0) ? txq0.size() : txq1.size();
    endfunction

    task automatic push_tx(input int m, input logic [7:0] d);
        int n;
        n = 0;
        while (!tx_ready[m] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_before_write", tx_ready[m], 1'b1);
        tx_data     = d;
        tx_valid[m] = 1'b1;
        @(negedge clk);
        tx_valid[m] = 1'b0;
        if (m == 0) txq0.push_back(d); else txq1.push_back(d);
        check("tx_ready_low_after_write", tx_ready[m], 1'b0);
    endtask

    // Controller side: sclk half period of 4 clk; mode index 1 is CPHA=1 (sample on trailing edge).
    task automatic run_frame(input int m, input int nbits, input logic [23:0] words,
                             input bit do_refill, input logic [7:0] refill,
                             input int rst_after, input string tag);
        int rx_base, ur_base, exp_ur, k, i;
        logic [8:0] ld;
        logic [7:0] exp_tx [4];
        logic [7:0] cap [3];
        bit reset_hit;
        rx_base   = rxv_cnt[m];
        ur_base   = urun_cnt[m];
        exp_ur    = 0;
        reset_hit = 1'b0;
        for (int j = 0; j < 4; j++) exp_tx[j] = 8'h00;
        for (int j = 0; j < 3; j++) cap[j] = 8'h00;

        cs_n[m] = 1'b0;
        ld = model_load(m);
        exp_tx[0] = ld[7:0];
        exp_ur += ld[8];
        wait_clk(4);
        check({tag, "_busy_in_frame"}, busy[m], 1'b1);
        check({tag, "_oe_in_frame"}, oe[m], 1'b1);
        check({tag, "_tx_ready_after_load"}, tx_ready[m], 1'b1);
        if (m == 1) check({tag, "_miso_before_first_edge"}, miso[m], 1'b0);
        if (do_refill) push_tx(m, refill);

        for (int b = 0; b < nbits; b++) begin
            k = b / 8;
            i = b % 8;
            if (!reset_hit && m == 1 && i == 0 && b != 0) begin
                ld = model_load(m);
                exp_tx[k] = ld[7:0];
                exp_ur += ld[8];
            end
            mosi = words[8*k + 7 - i];
            if (m == 0) cap[k][7-i] = miso[m];
            sclk[m] = ~sclk[m];
            wait_clk(4);
            if (m == 1) cap[k][7-i] = miso[m];
            sclk[m] = ~sclk[m];
            wait_clk(4);
            if (!reset_hit && m == 0 && i == 7) begin
                ld = model_load(m);
                exp_tx[k+1] = ld[7:0];
                exp_ur += ld[8];
            end
            if (b == rst_after) begin
                rst = 1'b1;
                wait_clk(1);
                rst = 1'b0;
                txq0.delete();
                txq1.delete();
                reset_hit = 1'b1;
                wait_clk(1);
                check({tag, "_rx_data_after_reset"}, rx_data[m], 8'h00);
                check({tag, "_busy_after_reset"}, busy[m], 1'b0);
            end
        end

        wait_clk(4);
        cs_n[m] = 1'b1;
        wait_clk(8);
        check({tag, "_rx_valid_count"}, rxv_cnt[m] - rx_base, reset_hit ? 0 : nbits / 8);
        check({tag, "_underrun_count"}, urun_cnt[m] - ur_base, exp_ur);
        check({tag, "_busy_after_cs"}, busy[m], 1'b0);
        check({tag, "_oe_after_cs"}, oe[m], 1'b0);
        if (!reset_hit) begin
            for (int w = 0; w < nbits / 8; w++) begin
                check({tag, "_rx_word"}, rx_log[m][(rx_base + w) % 8], words[8*w +: 8]);
                check({tag, "_miso_word"}, cap[w], exp_tx[w]);
            end
        end
    endtask

    initial begin
        int m, nw, nb;
        logic [23:0] rw;
        wait_clk(3);
        for (int d = 0; d < 2; d++) begin
            check("reset_miso", miso[d], 1'b0);
            check("reset_oe", oe[d], 1'b0);
            check("reset_tx_ready", tx_ready[d], 1'b1);
            check("reset_rx_data", rx_data[d], 8'h00);
            check("reset_rx_valid", rx_valid[d], 1'b0);
            check("reset_underrun", urun[d], 1'b0);
            check("reset_busy", busy[d], 1'b0);
        end
        rst = 1'b0;
        wait_clk(6);

        push_tx(0, 8'h3C);
        run_frame(0, 8, 24'h0000A5, 1'b0, 8'h00, -1, "m0_single");
        push_tx(1, 8'h3C);
        run_frame(1, 8, 24'h0000A5, 1'b0, 8'h00, -1, "m3_single");
        push_tx(1, 8'hF0);
        run_frame(1, 16, 24'h008001, 1'b1, 8'h0F, -1, "m3_back2back");
        run_frame(1, 8, 24'h0000A5, 1'b0, 8'h00, -1, "m3_empty_tx");
        run_frame(0, 5, 24'h0000FF, 1'b0, 8'h00, -1, "m0_abort5");
        run_frame(0, 8, 24'h00005A, 1'b0, 8'h00, -1, "m0_after_abort");
        run_frame(0, 8, 24'h0000FF, 1'b0, 8'h00, 2, "m0_reset_mid");
        run_frame(0, 8, 24'h0000C3, 1'b0, 8'h00, -1, "m0_after_reset");

        for (int r = 0; r < 10; r++) begin
            m  = $urandom_range(0, 1);
            nw = $urandom_range(1, 3);
            nb = nw * 8;
            if ($urandom_range(0, 3) == 0) nb = nb - $urandom_range(1, 7);
            rw = 24'($urandom);
            if (model_size(m) == 0 && $urandom_range(0, 1) == 1) push_tx(m, 8'($urandom));
            run_frame(m, nb, rw, 1'($urandom_range(0, 1)), 8'($urandom), -1, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
